// File: rtl/max_pool_feeder_pkg.sv
// max_pool_feeder_pkg: feeder states, repetition encodings and the most-negative value helper
package max_pool_feeder_pkg;
  typedef enum logic [1:0] {FILL, WAIT, OUT} state_t;
  localparam logic [1:0] REP_FIRST = 2'b00;
  localparam logic [1:0] REP_CONT = 2'b01;
  function automatic logic [63:0] min_val(input int width);
    return 64'(1) << (width - 1);
  endfunction
endpackage

// File: rtl/max_pool_feeder_if.sv
// max_pool_feeder_if: element stream in, tree port, window-max stream out
interface max_pool_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK = 32
);
  logic s_valid;
  logic s_ready;
  logic s_last;
  logic [DATA_WIDTH-1:0] s_data;
  logic [DATA_WIDTH*BANK-1:0] din;
  logic [1:0] repetition;
  logic [DATA_WIDTH-1:0] previous_data;
  logic [DATA_WIDTH-1:0] tree_dout;
  logic m_valid;
  logic m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  modport master (
    output s_valid, s_data, s_last, tree_dout, m_ready,
    input s_ready, din, repetition, previous_data, m_valid, m_data
  );
  modport slave (
    input s_valid, s_data, s_last, tree_dout, m_ready,
    output s_ready, din, repetition, previous_data, m_valid, m_data
  );
endinterface

// File: rtl/max_pool_feeder_lane_packer.sv
// max_pool_feeder_lane_packer: chunk lane buffer, cleared to MIN, written at lane_cnt
module max_pool_feeder_lane_packer
  import max_pool_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BANK = 32
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic wr,
  input logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH*BANK-1:0] lanes,
  output logic full
);
  localparam int CW = $clog2(BANK);
  localparam logic [DATA_WIDTH-1:0] MIN = DATA_WIDTH'(min_val(DATA_WIDTH));
  logic [CW-1:0] lane_cnt;
  assign full = lane_cnt == CW'(BANK - 1);
  // unwritten lanes keep MIN so short chunks never win the max
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      lanes <= {BANK{MIN}};
      lane_cnt <= '0;
    end else if (wr) begin
      lanes[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= wdata;
      lane_cnt <= lane_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/max_pool_feeder.sv
// max_pool_feeder: packs elements into tree chunks, folds partial maxima, emits one max per window; define MAX_POOL_FEEDER_RELU_EN to clamp m_data at zero
module max_pool_feeder
  import max_pool_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BANK = 32,
  parameter int RESULT_LATENCY = 6
) (
  input logic clk,
  input logic rst,
  max_pool_feeder_if.slave bus
);
  localparam int WW = $clog2(RESULT_LATENCY + 1);
  localparam logic [DATA_WIDTH-1:0] MIN = DATA_WIDTH'(min_val(DATA_WIDTH));
  state_t state;
  state_t state_n;
  logic full;
  logic accept;
  logic done;
  logic clear;
  logic first;
  logic last_chunk;
  logic s_ready;
  logic m_valid;
  logic [WW-1:0] wait_cnt;
  logic [DATA_WIDTH-1:0] prev_reg;
  logic [DATA_WIDTH-1:0] m_data;
  logic [DATA_WIDTH-1:0] loaded;
`ifdef MAX_POOL_FEEDER_RELU_EN
  assign loaded = bus.tree_dout[DATA_WIDTH-1] ? '0 : bus.tree_dout;
`else
  assign loaded = bus.tree_dout;
`endif
  max_pool_feeder_lane_packer #(.DATA_WIDTH(DATA_WIDTH), .BANK(BANK)) lane_packer (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .wr(accept),
    .wdata(bus.s_data),
    .lanes(bus.din),
    .full(full)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else state <= state_n;
  end
  // next state; the tree result is sampled on the last WAIT cycle, after din has been presented RESULT_LATENCY edges
  always_comb begin
    state_n = state;
    accept = s_ready && bus.s_valid;
    done = state == WAIT && wait_cnt == WW'(RESULT_LATENCY);
    clear = 1'b0;
    if (state == FILL && accept && (full || bus.s_last)) state_n = WAIT;
    if (done) begin
      state_n = last_chunk ? OUT : FILL;
      clear = !last_chunk;
    end
    if (state == OUT && bus.m_ready) begin
      state_n = FILL;
      clear = 1'b1;
    end
  end
  // registered handshakes, wait counter and window partial-max bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      first <= 1'b1;
      last_chunk <= 1'b0;
      wait_cnt <= '0;
      prev_reg <= MIN;
    end else begin
      s_ready <= state_n == FILL;
      m_valid <= state_n == OUT;
      wait_cnt <= state == WAIT && !done ? wait_cnt + 1'b1 : '0;
      if (accept) last_chunk <= bus.s_last;
      if (done) prev_reg <= bus.tree_dout;
      if (done && last_chunk) m_data <= loaded;
      if (done && !last_chunk) first <= 1'b0;
      if (state == OUT && bus.m_ready) begin
        first <= 1'b1;
        prev_reg <= MIN;
      end
    end
  end
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_data = m_data;
  assign bus.repetition = first ? REP_FIRST : REP_CONT;
  assign bus.previous_data = prev_reg;
endmodule
